snake_body_engine: RTL and testbench

SNAKE_BODY_ENGINE -- requirements
Module: snake_body_engine

---
 rtl/snake_body_engine_if.sv | 33 +++
 rtl/snake_body_engine.sv | 210 +++++++++++++++++++++
 tb/tb_snake_body_engine.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_body_engine_if.sv
// Command, status and segment-read signals between the snake game controller
// and the body engine. The controller holds the master side; the engine is the slave.
interface snake_body_engine_if #(
    parameter int COORD_BIT        = 7,
    parameter int SNAKE_LENGTH_BIT = 6
);
    logic                        step;
    logic [1:0]                  dir;
    logic                        grow;
    logic                        busy;
    logic                        done;
    logic                        game_over;
    logic                        full;
    logic [COORD_BIT-1:0]        head_x;
    logic [COORD_BIT-1:0]        head_y;
    logic [SNAKE_LENGTH_BIT:0]   snake_length;
    logic [SNAKE_LENGTH_BIT-1:0] rd_index;
    logic [COORD_BIT-1:0]        rd_x;
    logic [COORD_BIT-1:0]        rd_y;
    logic                        rd_valid;

    modport master (
        output step, dir, grow, rd_index,
        input  busy, done, game_over, full, head_x, head_y, snake_length,
               rd_x, rd_y, rd_valid
    );

    modport slave (
        input  step, dir, grow, rd_index,
        output busy, done, game_over, full, head_x, head_y, snake_length,
               rd_x, rd_y, rd_valid
    );
endinterface

// File: rtl/snake_body_engine.sv
// Snake body store and move engine: ring buffer of segments, wall and
// self-collision checking, and an independent registered read port for the renderer.
module snake_body_engine #(
    parameter int COORD_BIT        = 7,
    parameter int SNAKE_LENGTH_BIT = 6,
    parameter int GRID_X           = 80,
    parameter int GRID_Y           = 60,
    parameter int INIT_X           = 20,
    parameter int INIT_Y           = 15,
    parameter int INIT_LENGTH      = 3,
    parameter int WRAP             = 0
) (
    input logic clock_25,
    input logic reset,
    input logic sync_reset,
    snake_body_engine_if.slave bus
);
    localparam int DEPTH = 1 << SNAKE_LENGTH_BIT;

    typedef logic [COORD_BIT-1:0]        coord_t;
    typedef logic [SNAKE_LENGTH_BIT-1:0] ptr_t;
    typedef logic [SNAKE_LENGTH_BIT:0]   len_t;

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_SCAN   = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;
    localparam logic [2:0] S_DEAD   = 3'd5;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic   NO_WRAP   = (WRAP == 0);
    localparam coord_t X_MAX     = coord_t'(GRID_X - 1);
    localparam coord_t Y_MAX     = coord_t'(GRID_Y - 1);
    localparam ptr_t   INIT_HEAD = ptr_t'(INIT_LENGTH - 1);

    logic [2*COORD_BIT-1:0] mem [DEPTH];

    logic [2:0] state;
    ptr_t       head_ptr;
    ptr_t       init_cnt;
    len_t       scan_idx;
    logic [1:0] heading;
    logic       grow_l;
    coord_t     new_x, new_y;
    coord_t     head_x, head_y;
    len_t       snake_length;
    logic       done, game_over;

    logic       full;
    len_t       scan_n;
    ptr_t       scan_addr;
    logic       hit;
    coord_t     cand_x, cand_y;
    logic       wall;

    assign full      = (snake_length == len_t'(DEPTH));
    // When the move does not lengthen the snake, the tail vacates and may be entered.
    assign scan_n    = (grow_l && !full) ? snake_length : snake_length - len_t'(1);
    assign scan_addr = head_ptr - ptr_t'(scan_idx);
    assign hit       = (mem[scan_addr] == {new_x, new_y});

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        cand_x = head_x;
        cand_y = head_y;
        wall   = 1'b0;
        case (heading)
            DIR_UP: begin
                if (head_y == '0) begin wall = NO_WRAP; cand_y = Y_MAX; end
                else cand_y = head_y - coord_t'(1);
            end
            DIR_DOWN: begin
                if (head_y == Y_MAX) begin wall = NO_WRAP; cand_y = '0; end
                else cand_y = head_y + coord_t'(1);
            end
            DIR_LEFT: begin
                if (head_x == '0) begin wall = NO_WRAP; cand_x = X_MAX; end
                else cand_x = head_x - coord_t'(1);
            end
            default: begin
                if (head_x == X_MAX) begin wall = NO_WRAP; cand_x = '0; end
                else cand_x = head_x + coord_t'(1);
            end
        endcase
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state        <= S_INIT;
            head_ptr     <= INIT_HEAD;
            init_cnt     <= '0;
            scan_idx     <= '0;
            heading      <= DIR_RIGHT;
            grow_l       <= 1'b0;
            new_x        <= '0;
            new_y        <= '0;
            head_x       <= coord_t'(INIT_X);
            head_y       <= coord_t'(INIT_Y);
            snake_length <= len_t'(INIT_LENGTH);
            done         <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (sync_reset) begin
                state        <= S_INIT;
                head_ptr     <= INIT_HEAD;
                init_cnt     <= '0;
                heading      <= DIR_RIGHT;
                head_x       <= coord_t'(INIT_X);
                head_y       <= coord_t'(INIT_Y);
                snake_length <= len_t'(INIT_LENGTH);
                game_over    <= 1'b0;
            end else begin
                case (state)
                    S_INIT: begin
                        init_cnt <= init_cnt + ptr_t'(1);
                        if (init_cnt == INIT_HEAD) state <= S_IDLE;
                    end
                    S_IDLE: begin
                        if (bus.step) begin
                            grow_l <= bus.grow;
                            if (bus.dir != (heading ^ 2'b01)) heading <= bus.dir;
                            state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        new_x    <= cand_x;
                        new_y    <= cand_y;
                        scan_idx <= '0;
                        if (wall) begin
                            state     <= S_DEAD;
                            game_over <= 1'b1;
                            done      <= 1'b1;
                        end else if (scan_n == '0) begin
                            state <= S_COMMIT;
                        end else begin
                            state <= S_SCAN;
                        end
                    end
                    S_SCAN: begin
                        if (hit) begin
                            state     <= S_DEAD;
                            game_over <= 1'b1;
                            done      <= 1'b1;
                        end else if (scan_idx == scan_n - len_t'(1)) begin
                            state <= S_COMMIT;
                        end else begin
                            scan_idx <= scan_idx + len_t'(1);
                        end
                    end
                    S_COMMIT: begin
                        head_ptr <= head_ptr + ptr_t'(1);
                        head_x   <= new_x;
                        head_y   <= new_y;
                        if (grow_l && !full) snake_length <= snake_length + len_t'(1);
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                    S_DEAD:  state <= S_DEAD;
                    default: state <= S_INIT;
                endcase
            end
        end
    end

    // NOTE: the segment store has no reset; INIT rewrites every slot that can be read as valid.
    always_ff @(posedge clock_25) begin
        if (!sync_reset) begin
            if (state == S_INIT)
                mem[head_ptr - init_cnt] <= {coord_t'(INIT_X) - coord_t'(init_cnt), coord_t'(INIT_Y)};
            else if (state == S_COMMIT)
                mem[head_ptr + ptr_t'(1)] <= {new_x, new_y};
        end
    end

    logic [2*COORD_BIT-1:0] rd_word;
    coord_t                 rd_x, rd_y;
    logic                   rd_valid;

    assign rd_word = mem[head_ptr - bus.rd_index];

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            rd_x     <= '0;
            rd_y     <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_x     <= rd_word[2*COORD_BIT-1:COORD_BIT];
            rd_y     <= rd_word[COORD_BIT-1:0];
            rd_valid <= (len_t'(bus.rd_index) < snake_length);
        end
    end

    assign bus.busy         = (state == S_INIT) || (state == S_CHECK) ||
                              (state == S_SCAN) || (state == S_COMMIT);
    assign bus.done         = done;
    assign bus.game_over    = game_over;
    assign bus.full         = full;
    assign bus.head_x       = head_x;
    assign bus.head_y       = head_y;
    assign bus.snake_length = snake_length;
    assign bus.rd_x         = rd_x;
    assign bus.rd_y         = rd_y;
    assign bus.rd_valid     = rd_valid;
endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: a queue-based snake model tracks the body and
// predicts each move's outcome; one compare process checks status every cycle.
module tb_snake_body_engine;
    localparam int CB = 7, LB = 6, DEPTH = 64, GX = 80, GY = 60;

    logic clock_25 = 1'b0;
    logic reset    = 1'b0;
    logic srst_a   = 1'b0;
    logic srst_b   = 1'b0;

    always #5 clock_25 = ~clock_25;

    snake_body_engine_if #(.COORD_BIT(CB), .SNAKE_LENGTH_BIT(LB)) a_if ();
    snake_body_engine_if #(.COORD_BIT(CB), .SNAKE_LENGTH_BIT(LB)) b_if ();

    snake_body_engine #(.WRAP(0)) dut_a (
        .clock_25(clock_25), .reset(reset), .sync_reset(srst_a), .bus(a_if)
    );

    snake_body_engine #(.INIT_X(0), .INIT_Y(0), .INIT_LENGTH(1), .WRAP(1)) dut_b (
        .clock_25(clock_25), .reset(reset), .sync_reset(srst_b), .bus(b_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model of dut_a: body as coordinate queues, head at index 0.
    int m_x[$];
    int m_y[$];
    int m_heading;
    bit m_dead;

    int exp_hx, exp_hy, exp_len;
    bit exp_busy, exp_done, exp_go;
    bit cmp_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_x.delete();
        m_y.delete();
        for (int k = 0; k < 3; k++) begin
            m_x.push_back(20 - k);
            m_y.push_back(15);
        end
        m_heading = 3;
        m_dead    = 1'b0;
        exp_hx    = 20;
        exp_hy    = 15;
        exp_len   = 3;
        exp_busy  = 1'b1;
        exp_done  = 1'b0;
        exp_go    = 1'b0;
    endfunction

    always @(negedge clock_25) begin
        if (cmp_on) begin
            check("busy", a_if.busy, exp_busy);
            check("done", a_if.done, exp_done);
            check("game_over", a_if.game_over, exp_go);
            check("head_x", a_if.head_x, exp_hx);
            check("head_y", a_if.head_y, exp_hy);
            check("snake_length", a_if.snake_length, exp_len);
            check("full", a_if.full, exp_len == DEPTH);
        end
    end

    task automatic step_a(input logic [1:0] d, input bit g, input bit poke = 1'b0);
        int hd, nx, ny, n, sz;
        bit die, grows, seen;
        sz = m_x.size();
        hd = (int'(d) == (m_heading ^ 1)) ? m_heading : int'(d);
        nx = m_x[0];
        ny = m_y[0];
        case (hd)
            0: ny -= 1;
            1: ny += 1;
            2: nx -= 1;
            default: nx += 1;
        endcase
        die   = (nx < 0) || (nx >= GX) || (ny < 0) || (ny >= GY);
        grows = g && (sz < DEPTH);
        n     = grows ? sz : sz - 1;
        for (int i = 0; i < n; i++)
            if (m_x[i] == nx && m_y[i] == ny) die = 1'b1;

        @(negedge clock_25);
        a_if.step = 1'b1;
        a_if.dir  = d;
        a_if.grow = g;
        @(posedge clock_25);
        #1;
        a_if.step = 1'b0;
        a_if.grow = 1'b0;
        if (m_dead) begin
            repeat (5) @(posedge clock_25);
            return;
        end
        exp_busy = 1'b1;

        if (die) begin
            cmp_on = 1'b0;
            seen   = 1'b0;
            for (int k = 0; k < DEPTH + 8 && !seen; k++) begin
                @(negedge clock_25);
                seen = a_if.done;
            end
            check("death_done_seen", seen, 1);
            check("death_game_over", a_if.game_over, 1);
            check("death_busy", a_if.busy, 0);
            check("death_head_x", a_if.head_x, exp_hx);
            check("death_head_y", a_if.head_y, exp_hy);
            check("death_length", a_if.snake_length, exp_len);
            @(negedge clock_25);
            check("death_done_once", a_if.done, 0);
            m_dead   = 1'b1;
            exp_go   = 1'b1;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            cmp_on   = 1'b1;
            return;
        end

        m_heading = hd;
        for (int k = 1; k <= n + 2; k++) begin
            @(posedge clock_25);
            if (poke && k == 1) begin
                #1;
                a_if.step = 1'b1;
                a_if.dir  = 2'(hd ^ 2);
                a_if.grow = 1'b1;
            end
            if (poke && k == 2) begin
                #1;
                a_if.step = 1'b0;
                a_if.grow = 1'b0;
            end
            if (k == n + 2) begin
                m_x.push_front(nx);
                m_y.push_front(ny);
                if (!grows) begin
                    void'(m_x.pop_back());
                    void'(m_y.pop_back());
                end
                exp_busy = 1'b0;
                exp_done = 1'b1;
                exp_hx   = nx;
                exp_hy   = ny;
                exp_len  = m_x.size();
            end
        end
        @(posedge clock_25);
        exp_done = 1'b0;
    endtask

    // Restart with a competing step on the same edge; the restart must win.
    task automatic sync_a();
        @(negedge clock_25);
        srst_a    = 1'b1;
        a_if.step = 1'b1;
        a_if.dir  = 2'b00;
        @(posedge clock_25);
        #1;
        srst_a    = 1'b0;
        a_if.step = 1'b0;
        model_reset();
        repeat (3) @(posedge clock_25);
        exp_busy = 1'b0;
    endtask

    task automatic rd_lit(input string name, input int idx, input int ex, input int ey, input bit ev);
        @(negedge clock_25);
        a_if.rd_index = 6'(idx);
        @(posedge clock_25);
        #1;
        check({name, "_valid"}, a_if.rd_valid, ev);
        if (ev) begin
            check({name, "_x"}, a_if.rd_x, ex);
            check({name, "_y"}, a_if.rd_y, ey);
        end
    endtask

    task automatic rd_model(input int idx);
        rd_lit("rd_model", idx, (idx < m_x.size()) ? m_x[idx] : 0,
               (idx < m_y.size()) ? m_y[idx] : 0, idx < m_x.size());
    endtask

    task automatic step_b(input logic [1:0] d, input int ex, input int ey);
        int cyc;
        bit seen;
        @(negedge clock_25);
        b_if.step = 1'b1;
        b_if.dir  = d;
        @(posedge clock_25);
        #1;
        b_if.step = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(posedge clock_25);
            cyc++;
            #1;
            seen = b_if.done;
        end
        check("wrap_done_latency", cyc, 2);
        check("wrap_head_x", b_if.head_x, ex);
        check("wrap_head_y", b_if.head_y, ey);
        check("wrap_game_over", b_if.game_over, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        int cyc;
        a_if.step = 1'b0; a_if.dir = 2'b00; a_if.grow = 1'b0; a_if.rd_index = '0;
        b_if.step = 1'b0; b_if.dir = 2'b00; b_if.grow = 1'b0; b_if.rd_index = '0;
        model_reset();

        repeat (3) @(negedge clock_25);
        check("rst_busy", a_if.busy, 1);
        check("rst_done", a_if.done, 0);
        check("rst_game_over", a_if.game_over, 0);
        check("rst_full", a_if.full, 0);
        check("rst_head_x", a_if.head_x, 20);
        check("rst_head_y", a_if.head_y, 15);
        check("rst_length", a_if.snake_length, 3);
        check("rst_rd_x", a_if.rd_x, 0);
        check("rst_rd_y", a_if.rd_y, 0);
        check("rst_rd_valid", a_if.rd_valid, 0);
        check("rst_b_length", b_if.snake_length, 1);

        reset = 1'b1;
        cyc   = 0;
        do begin
            @(negedge clock_25);
            cyc++;
        end while (a_if.busy && cyc < 20);
        check("init_busy_clocks", cyc, 3);
        exp_busy = 1'b0;
        cmp_on   = 1'b1;

        rd_lit("init_seg0", 0, 20, 15, 1);
        rd_lit("init_seg1", 1, 19, 15, 1);
        rd_lit("init_seg2", 2, 18, 15, 1);
        rd_lit("init_seg3", 3, 0, 0, 0);

        step_a(2'b11, 1'b0);
        @(negedge clock_25);
        check("move_head_x", a_if.head_x, 21);
        check("move_head_y", a_if.head_y, 15);
        check("move_length", a_if.snake_length, 3);
        rd_lit("move_seg2", 2, 19, 15, 1);

        step_a(2'b10, 1'b0);
        @(negedge clock_25);
        check("reverse_head_x", a_if.head_x, 22);

        step_a(2'b01, 1'b0, 1'b1);
        @(negedge clock_25);
        check("busy_step_head_y", a_if.head_y, 16);
        check("busy_step_length", a_if.snake_length, 3);
        for (int i = 0; i < 4; i++) rd_model(i);

        sync_a();
        for (int i = 0; i < 59; i++) step_a(2'b11, 1'b0);
        @(negedge clock_25);
        check("edge_head_x", a_if.head_x, 79);
        step_a(2'b11, 1'b0);
        check("wall_game_over", a_if.game_over, 1);
        step_a(2'b01, 1'b0);
        @(negedge clock_25);
        check("dead_step_head_x", a_if.head_x, 79);
        check("dead_step_head_y", a_if.head_y, 15);
        sync_a();
        @(negedge clock_25);
        check("restart_head_x", a_if.head_x, 20);
        check("restart_head_y", a_if.head_y, 15);
        check("restart_length", a_if.snake_length, 3);
        check("restart_game_over", a_if.game_over, 0);

        for (int i = 0; i < 50; i++) step_a(2'b11, 1'b1);
        for (int i = 0; i < 10; i++) step_a(2'b01, 1'b1);
        step_a(2'b10, 1'b1);
        @(negedge clock_25);
        check("grow_full_length", a_if.snake_length, 64);
        check("grow_full_flag", a_if.full, 1);
        rd_model(0);
        rd_model(30);
        rd_model(63);
        step_a(2'b10, 1'b1);
        @(negedge clock_25);
        check("grow_when_full_length", a_if.snake_length, 64);
        check("grow_when_full_head_x", a_if.head_x, 68);
        step_a(2'b00, 1'b0);
        step_a(2'b11, 1'b0);
        step_a(2'b11, 1'b0);
        check("self_hit_game_over", a_if.game_over, 1);
        check("self_hit_head_x", a_if.head_x, 69);
        check("self_hit_head_y", a_if.head_y, 24);
        sync_a();

        step_b(2'b00, 0, 59);
        step_b(2'b10, 79, 59);
        step_b(2'b01, 79, 0);
        step_b(2'b11, 0, 0);

        cmp_on = 1'b0;
        @(negedge clock_25);
        a_if.step = 1'b1;
        a_if.dir  = 2'b11;
        @(posedge clock_25);
        #1;
        a_if.step = 1'b0;
        @(posedge clock_25);
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", a_if.busy, 1);
        check("abort_done", a_if.done, 0);
        check("abort_head_x", a_if.head_x, 20);
        check("abort_length", a_if.snake_length, 3);
        @(negedge clock_25);
        reset = 1'b1;
        cyc   = 0;
        do begin
            @(negedge clock_25);
            cyc++;
        end while (a_if.busy && cyc < 20);
        check("abort_init_clocks", cyc, 3);
        rd_lit("abort_seg0", 0, 20, 15, 1);
        rd_lit("abort_seg1", 1, 19, 15, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
